// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: request-to-send, start bit, LSB-first data,
// odd parity and stop, then the device acknowledge. Drives open-drain enables only.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 200,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done_tick,
  output logic       err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FL_W    = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, RTS, SETUP, SEND, ACK, WAIT_IDLE} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [WD_W-1:0]   wdog, wdog_n;
  logic [3:0]        bits, bits_n;
  logic [9:0]        shift, shift_n;
  logic              d_oe, d_oe_n;
  logic              ok, ok_n;
  logic              done_n, err_n;

  logic              ps2c_p0, ps2c_p1, ps2d_p0, ps2d_p1;
  logic              filt, fall;
  logic [FL_W-1:0]   filt_cnt;

  // Synchroniser stages and clock-line glitch filter
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_p0  <= 1'b1;
      ps2c_p1  <= 1'b1;
      ps2d_p0  <= 1'b1;
      ps2d_p1  <= 1'b1;
      filt     <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      ps2c_p0 <= ps2c_in;
      ps2c_p1 <= ps2c_p0;
      ps2d_p0 <= ps2d_in;
      ps2d_p1 <= ps2d_p0;
      fall    <= 1'b0;
      if (ps2c_p1 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FL_W'(FILTER_LEN - 1)) begin
        filt     <= ps2c_p1;
        filt_cnt <= '0;
        fall     <= filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wdog      <= '0;
      bits      <= '0;
      d_oe      <= 1'b0;
      ok        <= 1'b0;
      done_tick <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wdog      <= wdog_n;
      bits      <= bits_n;
      d_oe      <= d_oe_n;
      ok        <= ok_n;
      done_tick <= done_n;
      err       <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wdog_n  = wdog;
    bits_n  = bits;
    shift_n = shift;
    d_oe_n  = d_oe;
    ok_n    = ok;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        wdog_n = '0;
        if (wr) begin
          shift_n = {1'b1, ~^din, din};
          cnt_n   = '0;
          state_n = RTS;
        end
      end
      RTS: begin
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_n   = '0;
          d_oe_n  = 1'b1;
          state_n = SETUP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
          bits_n  = '0;
          wdog_n  = '0;
          state_n = SEND;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SEND: begin
        if (fall) begin
          d_oe_n  = ~shift[0];
          shift_n = {1'b0, shift[9:1]};
          bits_n  = bits + 1'b1;
          if (bits == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          ok_n    = ~ps2d_p1;
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (filt && ps2d_p1) begin
          done_n  = ok;
          err_n   = ~ok;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Watchdog spans the device-clocked phases; a timeout overrides any completion
    if (state == SEND || state == ACK || state == WAIT_IDLE) begin
      if (fall) begin
        wdog_n = '0;
      end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
        wdog_n  = '0;
        d_oe_n  = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b1;
        state_n = IDLE;
      end else begin
        wdog_n = wdog + 1'b1;
      end
    end
  end

  assign ps2c_oe = (state == RTS) || (state == SETUP);
  assign ps2d_oe = d_oe;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain line model and a PS/2 device
// model that clocks at a 200-cycle period, samples on rising edges and acks on clock 11.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int SETC = 4;
  localparam int TO   = 3000;
  localparam int FL   = 8;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, busy, done_tick, err;

  assign ps2c_in = ~ps2c_oe & dev_c;
  assign ps2d_in = ~ps2d_oe & dev_d;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SETC),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .din      (din),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .busy     (busy),
    .done_tick(done_tick),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int busy_pulse_cnt = 0;

  always @(negedge clk) begin
    done_cnt       <= done_cnt + (done_tick === 1'b1 ? 1 : 0);
    err_cnt        <= err_cnt + (err === 1'b1 ? 1 : 0);
    both_cnt       <= both_cnt + ((done_tick === 1'b1 && err === 1'b1) ? 1 : 0);
    busy_pulse_cnt <= busy_pulse_cnt + (((done_tick === 1'b1 || err === 1'b1) && busy !== 1'b0) ? 1 : 0);
  end

  logic [10:0] dev_rx;
  bit          dev_got;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_wr(input logic [7:0] b);
    din = b;
    wr  = 1'b1;
    cyc(1);
    wr  = 1'b0;
  endtask

  task automatic dev_run(input bit nack, input bit glitch, input int stop_after);
    int n;
    dev_got = 0;
    dev_rx  = '0;
    n = 0;
    while (ps2c_oe !== 1'b1 && n < 100) begin cyc(1); n++; end
    n = 0;
    while (ps2c_oe !== 1'b0 && n < 100) begin cyc(1); n++; end
    if (ps2c_oe !== 1'b0) return;
    dev_got = 1;
    cyc(HALF / 2);
    dev_rx[0] = ps2d_in;
    for (int k = 1; k <= 10; k++) begin
      dev_c = 1'b0;
      cyc(HALF);
      dev_c = 1'b1;
      dev_rx[k] = ps2d_in;
      if (k == stop_after) return;
      if (glitch && k == 3) begin
        cyc(40);
        dev_c = 1'b0;
        cyc(3);
        dev_c = 1'b1;
        cyc(HALF - 43);
      end else begin
        cyc(HALF);
      end
    end
    dev_d = nack;
    cyc(20);
    dev_c = 1'b0;
    cyc(HALF);
    dev_c = 1'b1;
    cyc(HALF / 2);
    dev_d = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    checks++;
    if ({ps2c_oe, ps2d_oe, busy, done_tick, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00000", {ps2c_oe, ps2d_oe, busy, done_tick, err});
    end
    cyc(30);
    checks++;
    if (busy !== 1'b0 || ps2c_oe !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b ps2c_oe=%b, expected 0 0", busy, ps2c_oe);
    end
  endtask

  task automatic test_basic;
    int c_lo, cd_lo, d0, e0, b0;
    logic post_c, post_d;
    d0 = done_cnt; e0 = err_cnt; b0 = busy_pulse_cnt;
    start_wr(8'hED);
    fork
      begin
        c_lo = 0; cd_lo = 0;
        while (ps2c_oe === 1'b1 && ps2d_oe === 1'b0 && c_lo < 100) begin c_lo++; cyc(1); end
        while (ps2c_oe === 1'b1 && ps2d_oe === 1'b1 && cd_lo < 100) begin cd_lo++; cyc(1); end
        post_c = ps2c_oe;
        post_d = ps2d_oe;
      end
      dev_run(1'b0, 1'b0, 0);
    join
    checks++;
    if (c_lo !== INH) begin errors++; $display("FAIL rts_len: got %0d cycles, expected %0d", c_lo, INH); end
    checks++;
    if (cd_lo !== SETC) begin errors++; $display("FAIL setup_len: got %0d cycles, expected %0d", cd_lo, SETC); end
    checks++;
    if (post_c !== 1'b0 || post_d !== 1'b1) begin
      errors++; $display("FAIL release: ps2c_oe=%b ps2d_oe=%b, expected 0 1", post_c, post_d);
    end
    checks++;
    if (dev_got !== 1'b1 || dev_rx !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
      errors++; $display("FAIL frame_ED: got %b, expected %b", dev_rx, {1'b1, 1'b1, 8'hED, 1'b0});
    end
    cyc(100);
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL done_ED: done cycles=%0d err cycles=%0d, expected 1 0", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if ({busy, ps2c_oe, ps2d_oe} !== 3'b000 || busy_pulse_cnt !== b0) begin
      errors++; $display("FAIL idle_after_ED: busy/oe=%b busy_at_pulse=%0d, expected 000 0",
                         {busy, ps2c_oe, ps2d_oe}, busy_pulse_cnt - b0);
    end
  endtask

  task automatic test_parity;
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h01};
    logic       par   [3] = '{1'b1, 1'b1, 1'b0};
    int d0;
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      start_wr(bytes[i]);
      dev_run(1'b0, 1'b0, 0);
      cyc(100);
      checks++;
      if (dev_rx[9] !== par[i] || dev_rx[8:1] !== bytes[i] || dev_rx[10] !== 1'b1 || dev_rx[0] !== 1'b0) begin
        errors++; $display("FAIL parity_%02h: frame %b, expected parity %b", bytes[i], dev_rx, par[i]);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
        errors++; $display("FAIL parity_done_%02h: done cycles=%0d, expected 1", bytes[i], done_cnt - d0);
      end
    end
  endtask

  task automatic test_timeout;
    int n, e0, d0;
    e0 = err_cnt; d0 = done_cnt;
    start_wr(8'hFF);
    n = 0;
    while (ps2c_oe !== 1'b0 && n < 100) begin cyc(1); n++; end
    n = 0;
    while (err !== 1'b1 && n < 4000) begin cyc(1); n++; end
    checks++;
    if (n < TO - 2 || n > TO + 2) begin
      errors++; $display("FAIL timeout_time: err after %0d cycles, expected about %0d", n, TO);
    end
    checks++;
    if ({ps2c_oe, ps2d_oe, busy} !== 3'b000) begin
      errors++; $display("FAIL timeout_lines: oe/busy=%b, expected 000", {ps2c_oe, ps2d_oe, busy});
    end
    cyc(20);
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      errors++; $display("FAIL timeout_pulse: err cycles=%0d done cycles=%0d, expected 1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_nack;
    int e0, d0;
    e0 = err_cnt; d0 = done_cnt;
    start_wr(8'hF4);
    dev_run(1'b1, 1'b0, 0);
    cyc(100);
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      errors++; $display("FAIL nack: err cycles=%0d done cycles=%0d, expected 1 0", err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy: busy=%b, expected 0", busy); end
  endtask

  task automatic test_glitch;
    int d0;
    d0 = done_cnt;
    start_wr(8'h5A);
    dev_run(1'b0, 1'b1, 0);
    cyc(100);
    checks++;
    if (dev_rx !== {1'b1, 1'b1, 8'h5A, 1'b0}) begin
      errors++; $display("FAIL glitch_frame: got %b, expected %b", dev_rx, {1'b1, 1'b1, 8'h5A, 1'b0});
    end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL glitch_done: done cycles=%0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    int d0, e0;
    d0 = done_cnt;
    start_wr(8'hA5);
    fork
      dev_run(1'b0, 1'b0, 0);
      begin
        cyc(600);
        din = 8'h3C;
        wr  = 1'b1;
        cyc(1);
        wr  = 1'b0;
      end
    join
    cyc(100);
    checks++;
    if (dev_rx !== {1'b1, 1'b1, 8'hA5, 1'b0} || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL wr_ignored: frame %b done cycles=%0d, expected %b and 1",
                         dev_rx, done_cnt - d0, {1'b1, 1'b1, 8'hA5, 1'b0});
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_ignored_busy: busy=%b, expected 0", busy); end

    d0 = done_cnt; e0 = err_cnt;
    start_wr(8'h30);
    dev_run(1'b0, 1'b0, 4);
    cyc(10);
    checks++;
    if (busy !== 1'b1 || ps2d_oe !== 1'b1) begin
      errors++; $display("FAIL abort_pre: busy=%b ps2d_oe=%b, expected 1 1", busy, ps2d_oe);
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++;
    if ({ps2c_oe, ps2d_oe, busy} !== 3'b000) begin
      errors++; $display("FAIL abort_reset: oe/busy=%b, expected 000", {ps2c_oe, ps2d_oe, busy});
    end
    cyc(50);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL abort_pulses: done=%0d err=%0d, expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    start_wr(8'hF4);
    dev_run(1'b0, 1'b0, 0);
    cyc(100);
    checks++;
    if (dev_rx !== {1'b1, 1'b0, 8'hF4, 1'b0} || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL after_reset_F4: frame %b done cycles=%0d, expected %b and 1",
                         dev_rx, done_cnt - d0, {1'b1, 1'b0, 8'hF4, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_timeout();
    test_nack();
    test_glitch();
    test_back_to_back();
    checks++;
    if (both_cnt !== 0 || busy_pulse_cnt !== 0) begin
      errors++; $display("FAIL pulse_rules: overlap=%0d busy_at_pulse=%0d, expected 0 0", both_cnt, busy_pulse_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED LED set, 0xFF reset, 0xF4 enable.
- Sits beside the key2state receive path on the same ps2c/ps2d pins, through open-drain pads. The top level ties ps2c = ps2c_oe ? 0 : z, and the same for ps2d.
- The receiver ignores the line while busy=1.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles clock is held low for request-to-send (120 us at 100 MHz).
- SETUP_CYCLES, 200: cycles data and clock are both held low before clock release.
- TIMEOUT_CYCLES, 1500000: watchdog limit between device clock edges (15 ms).
- FILTER_LEN, 8: consecutive equal samples required to change the filtered ps2c level.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous active-high reset
- wr  in  1  start request, sampled in IDLE only
- din  in  8  byte to send, latched on accepted wr
- ps2c_in  in  1  raw PS/2 clock pin level
- ps2d_in  in  1  raw PS/2 data pin level
- ps2c_oe  out  1  1 = pull clock low
- ps2d_oe  out  1  1 = pull data low
- busy  out  1  transfer in progress (state != IDLE)
- done_tick  out  1  one-cycle pulse: byte acknowledged
- err  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Reset values: ps2c_oe=0, ps2d_oe=0, busy=0, done_tick=0, err=0, state=IDLE, filtered clock=1, watchdog=0.
- Input conditioning: ps2c_in and ps2d_in pass through 2-FF synchronisers.
  - Filtered clock goes to 0 after FILTER_LEN consecutive 0 samples and to 1 after FILTER_LEN consecutive 1 samples.
  - fall = filtered 1->0, a one-cycle strobe.
  - Any glitch shorter than FILTER_LEN cycles is ignored.
- IDLE: both oe=0.
  - wr=1 latches shift register {1 (stop), ~^din (odd parity), din}.
  - Next state RTS, counter cleared.
  - wr while busy is ignored.
- RTS: ps2c_oe=1, ps2d_oe=0 for exactly INHIBIT_CYCLES cycles, then SETUP.
- SETUP: ps2c_oe=1, ps2d_oe=1 (start bit) for SETUP_CYCLES cycles.
  - Then ps2c_oe=0, ps2d_oe held at 1, bit counter=0, watchdog=0, go SEND.
- SEND: on each fall, ps2d_oe <= ~shift[0], shift right, count+1.
  - Falls 1-8 present d0..d7 (LSB first).
  - Fall 9 presents parity.
  - Fall 10 presents stop, so ps2d_oe=0.
  - After fall 10, go ACK.
- ACK: on the next fall, sample synchronised ps2d.
  - 0 = ack: flag ok.
  - 1 = NACK: flag fail.
  - Go WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock=1 and synchronised ps2d=1.
  - Then pulse done_tick (ok) or err (fail) for one cycle.
  - Go IDLE.
- Watchdog (SEND, ACK, WAIT_IDLE): increments every cycle and clears on each fall.
  - On reaching TIMEOUT_CYCLES: both oe=0, err pulses one cycle, state IDLE.
- done_tick and err never assert together.
  - busy drops in the same cycle the pulse is asserted.
  - A new wr is accepted the following cycle.
- rst in any state: the next edge forces the reset values, with no done_tick or err pulse.
- ps2d_oe only changes on fall events, or at SETUP entry/exit, or on timeout/reset.

Test Plan:
Bench parameters: INHIBIT_CYCLES=20, SETUP_CYCLES=4, TIMEOUT_CYCLES=3000, FILTER_LEN=8. The device model clocks at a 200-cycle period, samples data on the rising edge and acks on the 11th clock.

1. wr with din=0xED -> clock low 20 cycles, then data low 4 cycles, then clock released. Device samples 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. Device acks -> done_tick exactly one cycle, busy 0, both oe 0.
2. Parity: din=0x00 -> parity bit 1; din=0xFF -> parity bit 1; din=0x01 -> parity bit 0. Each ends in done_tick.
3. Device never clocks after clock release -> after 3000 cycles err pulses once, ps2c_oe=0, ps2d_oe=0, busy=0.
4. Device holds data high on the 11th clock (NACK) -> err pulses after the lines go idle; done_tick stays 0.
5. A 3-cycle low glitch on ps2c_in mid-SEND -> no bit advance; the received byte still equals din, then done_tick.
6. wr pulsed again during SEND -> ignored, first byte completes. rst asserted after fall 4 -> next cycle both oe=0, busy=0, no pulses. A fresh wr with 0xF4 then completes normally.
